mesh_port_bank: RTL

Parametrised bank of buffered mesh ports sitting between a tile core and its NUM_PORTS mesh neighbours. Each port owns one receive FIFO and one transmit FIFO, so the core can post and consume words without stalling on neighbour handshakes. The receive side offers two modes: a directed read from one chosen port, or a round-robin "any port" read that reports the source port. It generalises the fixed four-port, unbuffered tile-edge wiring to arbitrary port count, width and depth.

---
 rtl/mesh_pkg.sv | 11 +
 rtl/mesh_fifo.sv | 60 ++++++
 rtl/mesh_port_bank.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh port bank: neighbour port indices and the
// standard 32-bit mesh word type.
package mesh_pkg;
    localparam int unsigned PORT_UP     = 0;
    localparam int unsigned PORT_DOWN   = 1;
    localparam int unsigned PORT_LEFT   = 2;
    localparam int unsigned PORT_RIGHT  = 3;
    localparam int unsigned MESH_WORD_W = 32;

    typedef logic [MESH_WORD_W-1:0] mesh_word_t;
endpackage

// File: rtl/mesh_fifo.sv
// Single-clock FIFO used for every per-port RX and TX buffer in the bank.
// Full does not look ahead at a same-cycle pop.
module mesh_fifo
    import mesh_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = push && !full;
    assign w_rd  = pop && !empty;
    assign rdata = r_mem[r_rptr];

    // Storage array; contents are only meaningful while count covers them.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mesh_port_bank.sv
// Buffered bank of mesh ports: one RX and one TX FIFO per neighbour, with a
// directed or round-robin read port towards the core.
module mesh_port_bank
    import mesh_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_PORTS*WIDTH-1:0] recv_data,
    input  logic [NUM_PORTS-1:0]       recv_valid,
    output logic [NUM_PORTS-1:0]       recv_ready,
    output logic [NUM_PORTS*WIDTH-1:0] send_data,
    output logic [NUM_PORTS-1:0]       send_ready,
    input  logic [NUM_PORTS-1:0]       send_done,
    input  logic                       tx_valid,
    input  logic [PW-1:0]              tx_port,
    input  logic [WIDTH-1:0]           tx_data,
    output logic                       tx_ready,
    input  logic                       rx_any,
    input  logic [PW-1:0]              rx_port_sel,
    output logic                       rx_valid,
    output logic [WIDTH-1:0]           rx_data,
    output logic [PW-1:0]              rx_port,
    input  logic                       rx_ready,
    output logic [NUM_PORTS-1:0]       rx_empty,
    output logic [NUM_PORTS-1:0]       tx_full
);
    logic [NUM_PORTS-1:0] w_rx_full;
    logic [NUM_PORTS-1:0] w_tx_empty;
    logic [NUM_PORTS-1:0] w_rx_push;
    logic [NUM_PORTS-1:0] w_rx_pop;
    logic [NUM_PORTS-1:0] w_tx_push;
    logic [NUM_PORTS-1:0] w_tx_pop;
    logic [WIDTH-1:0]     w_rx_head [NUM_PORTS];
    logic [WIDTH-1:0]     w_tx_head [NUM_PORTS];
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        w_any_grant;
    logic                 w_any_found;
    logic [PW-1:0]        w_grant;

    // Port index arithmetic modulo NUM_PORTS (base and offset stay below it).
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return PW'(s);
    endfunction

    assign recv_ready = nrst ? '0 : ~w_rx_full;
    assign send_ready = nrst ? '0 : ~w_tx_empty;
    assign w_rx_push  = recv_valid & recv_ready;
    assign w_tx_pop   = send_ready & send_done;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mesh_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .push  (w_rx_push[p]),
            .pop   (w_rx_pop[p]),
            .wdata (recv_data[p*WIDTH +: WIDTH]),
            .rdata (w_rx_head[p]),
            .full  (w_rx_full[p]),
            .empty (rx_empty[p])
        );
        mesh_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .push  (w_tx_push[p]),
            .pop   (w_tx_pop[p]),
            .wdata (tx_data),
            .rdata (w_tx_head[p]),
            .full  (tx_full[p]),
            .empty (w_tx_empty[p])
        );
        assign send_data[p*WIDTH +: WIDTH] = w_tx_empty[p] ? '0 : w_tx_head[p];
        assign w_tx_push[p] = tx_valid && tx_ready && (tx_port == PW'(p));
        assign w_rx_pop[p]  = rx_valid && rx_ready && (w_grant == PW'(p));
    end

    // Core push acceptance; out-of-range destinations are never accepted.
    always_comb begin
        tx_ready = 1'b0;
        if (nrst) begin
            tx_ready = 1'b0;
        end else if (int'(tx_port) < NUM_PORTS) begin
            tx_ready = !tx_full[tx_port];
        end else begin
            tx_ready = 1'b0;
        end
    end

    // Round-robin search: first non-empty RX FIFO at or after r_rr_ptr.
    always_comb begin
        w_any_found = 1'b0;
        w_any_grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_any_found && !rx_empty[wrap_add(r_rr_ptr, i)]) begin
                w_any_found = 1'b1;
                w_any_grant = wrap_add(r_rr_ptr, i);
            end else begin
                w_any_found = w_any_found;
            end
        end
    end

    // Core read port: grant selection and zero-masked outputs.
    always_comb begin
        w_grant  = rx_any ? w_any_grant : rx_port_sel;
        rx_valid = 1'b0;
        if (nrst) begin
            rx_valid = 1'b0;
        end else if (rx_any) begin
            rx_valid = w_any_found;
        end else if (int'(rx_port_sel) < NUM_PORTS) begin
            rx_valid = !rx_empty[rx_port_sel];
        end else begin
            rx_valid = 1'b0;
        end
        rx_data = rx_valid ? w_rx_head[w_grant] : '0;
        rx_port = rx_valid ? w_grant : '0;
    end

    // Round-robin pointer advances only on any-mode pops.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_rr_ptr <= '0;
        end else if (rx_any && rx_valid && rx_ready) begin
            r_rr_ptr <= wrap_add(w_grant, 1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
endmodule
